// File: rtl/colour_msg_tx.sv
// Colour-change UART announcer: debounces a one-hot colour indication and sends
// "C<colour>\n" (8N1) whenever a newly stable colour differs from the last one sent.
module colour_msg_tx #(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned STABLE_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_led,
  input  logic       green_led,
  input  logic       blue_led,
  output logic       tx,
  output logic       busy,
  output logic [7:0] msg_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STAB_PRE  = SW'(STABLE_CYCLES - 2);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {COL_NONE, COL_R, COL_G, COL_B} colour_t;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          red_q, green_q, blue_q;
  colour_t       dec, prev_dec, last_sent, cur_col, pend_col;
  logic          pend_valid;
  logic [SW-1:0] stab_cnt;
  logic [BW-1:0] baud_cnt;
  logic [1:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    colour_char, cur_byte;
  logic          accept, accept_col;

  always_comb begin
    dec = COL_NONE;
    case ({red_q, green_q, blue_q})
      3'b100:  dec = COL_R;
      3'b010:  dec = COL_G;
      3'b001:  dec = COL_B;
      default: dec = COL_NONE;
    endcase
  end

  // Acceptance coincides with the edge on which the counter steps to STABLE_CYCLES-1.
  assign accept     = (dec == prev_dec) && (stab_cnt == STAB_PRE);
  assign accept_col = accept && (dec != COL_NONE);

  always_comb begin
    colour_char = 8'h42;
    case (cur_col)
      COL_R:   colour_char = 8'h52;
      COL_G:   colour_char = 8'h47;
      default: colour_char = 8'h42;
    endcase
    cur_byte = 8'h0A;
    case (byte_idx)
      2'd0:    cur_byte = 8'h43;
      2'd1:    cur_byte = colour_char;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      blue_q     <= 1'b0;
      prev_dec   <= COL_NONE;
      stab_cnt   <= '0;
      last_sent  <= COL_NONE;
      cur_col    <= COL_NONE;
      pend_col   <= COL_NONE;
      pend_valid <= 1'b0;
      state      <= IDLE;
      baud_cnt   <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      msg_count  <= '0;
    end else begin
      red_q   <= red_led;
      green_q <= green_led;
      blue_q  <= blue_led;

      if (dec != prev_dec) begin
        prev_dec <= dec;
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_LAST) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      // Requests arriving mid-message: newest wins, and the colour already on the wire is dropped.
      if (state != IDLE && accept_col) begin
        pend_valid <= (dec != cur_col);
        pend_col   <= dec;
      end

      case (state)
        IDLE: begin
          tx         <= 1'b1;
          busy       <= 1'b0;
          baud_cnt   <= '0;
          pend_valid <= 1'b0;
          if (accept_col && dec != last_sent) begin
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
            cur_col   <= dec;
            last_sent <= dec;
            byte_idx  <= '0;
          end else if (pend_valid && pend_col != last_sent) begin
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
            cur_col   <= pend_col;
            last_sent <= pend_col;
            byte_idx  <= '0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx == 2'd2) begin
              state     <= IDLE;
              tx        <= 1'b1;
              busy      <= 1'b0;
              msg_count <= msg_count + 8'd1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
